// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC and requests one 32-bit word at a time
// from instruction memory. It latches the word into an instruction register
// and hands it downstream with a valid/ready handshake.
// A redirect (pc_load) issued mid-request discards the stale response.
// If the memory does not acknowledge within ACK_TIMEOUT request cycles, the
// unit enters a sticky fault state.
// Optional feature macro: MISALIGN_TRAP_EN. When it is defined, a fetch whose
// target address is not 4-byte aligned faults instead of issuing a request.
module instr_fetch_unit #(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    input  logic        pc_load,
    input  logic [63:0] pc_in,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [63:0] pc_out,
    output logic        fault
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    localparam logic [8:0] TIMEOUT = 9'(ACK_TIMEOUT);

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic [1:0]  state;
    logic [63:0] pc;
    logic [63:0] pc_held;
    logic [31:0] ir;
    logic        flush;
    logic [7:0]  wait_cnt;
    logic        fault_q;
    logic [8:0]  wait_next;
    logic [63:0] pc_plus4;

    // A target may be fetched unless the misalignment trap rejects it.
    function automatic logic can_enter(input logic [1:0] low_bits);
        return !TRAP_EN || (low_bits == 2'b00);
    endfunction

    // Next wait count and sequential PC.
    always_comb begin
        wait_next = {1'b0, wait_cnt} + 9'd1;
        pc_plus4  = pc + 64'd4;
    end

    // Fetch FSM together with its PC, instruction register and timeout counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            pc_held  <= RESET_PC;
            ir       <= '0;
            flush    <= 1'b0;
            wait_cnt <= '0;
            fault_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pc_load) begin
                        pc       <= pc_in;
                        state    <= can_enter(pc_in[1:0]) ? S_REQ : S_FAULT;
                        fault_q  <= !can_enter(pc_in[1:0]);
                        wait_cnt <= '0;
                        flush    <= 1'b0;
                    end else if (fetch_en) begin
                        state    <= can_enter(pc[1:0]) ? S_REQ : S_FAULT;
                        fault_q  <= !can_enter(pc[1:0]);
                        wait_cnt <= '0;
                        flush    <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (pc_load) begin
                        // The redirect restarts the timeout for the new
                        // address. An ack in the same cycle belongs to the
                        // old address, so no later ack needs discarding.
                        pc       <= pc_in;
                        wait_cnt <= '0;
                        flush    <= !mem_ack;
                        if (!can_enter(pc_in[1:0])) begin
                            state   <= S_FAULT;
                            fault_q <= 1'b1;
                            flush   <= 1'b0;
                        end
                    end else if (mem_ack) begin
                        wait_cnt <= '0;
                        if (flush) begin
                            flush <= 1'b0;
                        end else begin
                            ir      <= mem_rdata;
                            pc_held <= pc;
                            state   <= S_VALID;
                        end
                    end else begin
                        wait_cnt <= wait_next[7:0];
                        if (wait_next >= TIMEOUT) begin
                            state   <= S_FAULT;
                            fault_q <= 1'b1;
                            flush   <= 1'b0;
                        end
                    end
                end
                S_VALID: begin
                    if (pc_load) begin
                        pc       <= pc_in;
                        state    <= can_enter(pc_in[1:0]) ? S_REQ : S_FAULT;
                        fault_q  <= !can_enter(pc_in[1:0]);
                        wait_cnt <= '0;
                        flush    <= 1'b0;
                    end else if (instr_ready) begin
                        pc <= pc_plus4;
                        if (fetch_en) begin
                            state    <= can_enter(pc_plus4[1:0]) ? S_REQ : S_FAULT;
                            fault_q  <= !can_enter(pc_plus4[1:0]);
                            wait_cnt <= '0;
                            flush    <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_FAULT: begin
                    if (pc_load) begin
                        pc       <= pc_in;
                        state    <= can_enter(pc_in[1:0]) ? S_REQ : S_FAULT;
                        fault_q  <= !can_enter(pc_in[1:0]);
                        wait_cnt <= '0;
                        flush    <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs decoded from state and the instruction register.
    always_comb begin
        mem_req     = (state == S_REQ);
        instr_valid = (state == S_VALID);
        mem_addr    = TRAP_EN ? pc : {pc[63:2], 2'b00};
        instruction = ir;
        opcode      = ir[6:0];
        rd          = ir[11:7];
        funct3      = ir[14:12];
        rs1         = ir[19:15];
        rs2         = ir[24:20];
        pc_out      = pc_held;
        fault       = fault_q;
    end

endmodule
